count_seq_checker: RTL and testbench
====================================

COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 5: width of observed count.
REQ-002 SHALL have parameter LOCK_LEN, default 4: consecutive good increments required to lock.
REQ-003 SHALL have parameter ERR_W, default 8: width of error counter.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clr  input  1  synchronous clear of lock state and error count.
REQ-007 SHALL have port valid  input  1  count_in is a sample this cycle.
REQ-008 SHALL have port count_in  input  WIDTH  observed up-counter value.
REQ-009 SHALL have port locked  output  1  checker is tracking a correct sequence.
REQ-010 SHALL have port err_pulse  output  1  one-cycle flag, sequence break while locked.
REQ-011 SHALL have port wrap_pulse  output  1  one-cycle flag, locked wrap from all-ones to 0.
REQ-012 SHALL have port err_count  output  ERR_W  saturating count of sequence breaks.

Function
REQ-013 SHALL implement states IDLE (no stored sample), ACQUIRE (stored sample, building run), LOCKED.
REQ-014 SHALL treat a sample as good when count_in equals (prev + 1) mod 2^WIDTH, prev being the last accepted sample.
REQ-015 SHALL, with valid=0, hold state, prev, run length and err_count; err_pulse and wrap_pulse SHALL be 0 next cycle.
REQ-016 SHALL, in IDLE with valid=1, store count_in as prev, clear run, go to ACQUIRE; no flags.
REQ-017 SHALL, in ACQUIRE with valid=1 and good sample, increment run; when run reaches LOCK_LEN, enter LOCKED.
REQ-018 SHALL, in ACQUIRE with valid=1 and bad sample, clear run, stay in ACQUIRE, raise no error.
REQ-019 SHALL, in LOCKED with valid=1 and bad sample, assert err_pulse next cycle, increment err_count, clear run, go to ACQUIRE.
REQ-020 SHALL store every valid sample as prev in ACQUIRE and LOCKED, good or bad.
REQ-021 SHALL, in LOCKED with valid=1, prev all-ones and count_in=0, assert wrap_pulse next cycle.
REQ-022 SHALL saturate err_count at 2^ERR_W-1; further breaks still pulse err_pulse.
REQ-023 SHALL register all outputs: one-cycle latency from sampling edge; locked high from the cycle after the locking sample.
REQ-024 SHALL give clr priority over valid: on clr, go to IDLE, zero err_count, run and flags, and discard that sample.
REQ-025 SHALL treat a repeated value (count_in == prev) as a bad sample.

Reset
REQ-026 SHALL, while reset=1, force state IDLE, prev=0, run=0, locked=0, err_pulse=0, wrap_pulse=0, err_count=0, independent of clk.
REQ-027 SHALL resume at the first rising clk edge after reset deasserts, requiring full re-acquisition; an asserted reset mid-LOCKED discards lock immediately.

Structure
REQ-028 SHALL take the state enum type and default parameter constants from shared package count_chk_pkg.
REQ-029 SHALL implement err_count in one sub-module sat_counter (parameter width, inputs inc and clr, saturating output).
REQ-030 SHALL size the run counter to hold LOCK_LEN, with no wider arithmetic; the prev+1 compare SHALL wrap at WIDTH bits.

Verification
REQ-031 SHALL cover: reset, then valid samples 0,1,2,3,4 -> locked=1 from the cycle after sample 4; err_count=0.
REQ-032 SHALL cover: locked, then samples 29,30,31,0,1 -> one wrap_pulse after sample 0; no err_pulse.
REQ-033 SHALL cover: locked at 10, then sample 15 -> err_pulse one cycle, err_count=1, locked=0; then 16,17,18,19 -> locked=1 again.
REQ-034 SHALL cover: locked, valid=0 for 5 cycles, then next value -> still locked, no flags; then repeat previous value -> err_pulse.
REQ-035 SHALL cover: 260 forced breaks with ERR_W=8 -> err_count saturates at 255; clr with valid=1 -> IDLE, err_count=0, sample ignored.
REQ-036 SHALL cover: reset asserted mid-LOCKED between clock edges -> locked=0 and err_count=0 immediately; checked against golden up5bit_counter as stimulus source.

Source files
------------

// File: rtl/count_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : count_chk_pkg
// Purpose : Shared state type and default parameters for count_seq_checker.
// Rev     : 1.0  initial release
// ============================================================================
package count_chk_pkg;

    localparam int DEF_WIDTH    = 5;
    localparam int DEF_LOCK_LEN = 4;
    localparam int DEF_ERR_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } chk_state_e;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : Up-counter that sticks at all-ones; clr has priority over inc.
// Rev     : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/count_seq_checker.sv
`default_nettype none
// ============================================================================
// Module  : count_seq_checker
// Purpose : Watches a sampled up-counter, locks onto a clean run and flags
//           sequence breaks and wraps while locked.
// Rev     : 1.0  initial release
// ============================================================================
module count_seq_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_LEN = DEF_LOCK_LEN,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             valid,
    input  logic [WIDTH-1:0] count_in,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int RUN_W = $clog2(LOCK_LEN + 1);

    chk_state_e       r_state;
    chk_state_e       w_next_state;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_next_prev;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] w_next_run;
    logic             r_locked;
    logic             r_err;
    logic             r_wrap;
    logic [WIDTH-1:0] w_prev_inc;
    logic             w_good;
    logic             w_err_hit;
    logic             w_wrap_hit;

    // Natural WIDTH-bit wrap makes all-ones -> 0 a good step.
    assign w_prev_inc = r_prev + WIDTH'(1);
    assign w_good     = (count_in == w_prev_inc);

    always_comb begin
        w_next_state = r_state;
        w_next_prev  = r_prev;
        w_next_run   = r_run;
        w_err_hit    = 1'b0;
        w_wrap_hit   = 1'b0;

        if (clr) begin
            w_next_state = ST_IDLE;
            w_next_run   = '0;
        end else if (valid) begin
            w_next_prev = count_in;
            unique case (r_state)
                ST_IDLE: begin
                    w_next_run   = '0;
                    w_next_state = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (!w_good) begin
                        w_next_run = '0;
                    end else if (r_run == RUN_W'(LOCK_LEN - 1)) begin
                        w_next_run   = RUN_W'(LOCK_LEN);
                        w_next_state = ST_LOCKED;
                    end else begin
                        w_next_run = r_run + RUN_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (w_good) begin
                        w_wrap_hit = (r_prev == '1) && (count_in == '0);
                    end else begin
                        w_err_hit    = 1'b1;
                        w_next_run   = '0;
                        w_next_state = ST_ACQUIRE;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_next_run   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_prev   <= '0;
            r_run    <= '0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_prev   <= w_next_prev;
            r_run    <= w_next_run;
            r_locked <= (w_next_state == ST_LOCKED);
            r_err    <= w_err_hit;
            r_wrap   <= w_wrap_hit;
        end
    end

    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (reset),
        .clr   (clr),
        .inc   (w_err_hit),
        .count (err_count)
    );

    assign locked     = r_locked;
    assign err_pulse  = r_err;
    assign wrap_pulse = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_count_seq_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_count_seq_checker
// Purpose : Self-checking bench: directed vector table, corner sequences and
//           randomized traffic against a history-based reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_count_seq_checker;

    localparam int W        = 5;
    localparam int LOCK_LEN = 4;
    localparam int ERR_W    = 8;
    localparam int MODV     = 1 << W;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic             clk;
    logic             reset;
    logic             clr;
    logic             valid;
    logic [W-1:0]     count_in;
    logic             locked;
    logic             err_pulse;
    logic             wrap_pulse;
    logic [ERR_W-1:0] err_count;

    int n_pass  = 0;
    int n_total = 0;

    count_seq_checker #(
        .WIDTH    (W),
        .LOCK_LEN (LOCK_LEN),
        .ERR_W    (ERR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .valid      (valid),
        .count_in   (count_in),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .wrap_pulse (wrap_pulse),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit c;
        bit v;
        int x;
        bit el;
        bit ee;
        bit ew;
        int ec;
    } vec_t;

    vec_t tbl[$];

    // Reference model: samples accepted since the last IDLE entry.
    int m_hist[$];
    bit m_locked;
    int m_errcnt;

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic chk_out(string tag, int el, int ee, int ew, int ec);
        chk({tag, ".locked"},     int'(locked),     el);
        chk({tag, ".err_pulse"},  int'(err_pulse),  ee);
        chk({tag, ".wrap_pulse"}, int'(wrap_pulse), ew);
        chk({tag, ".err_count"},  int'(err_count),  ec);
    endtask

    task automatic step(bit c, bit v, int x);
        clr      = c;
        valid    = v;
        count_in = W'(x);
        @(posedge clk);
        #1;
    endtask

    function automatic void add(bit c, bit v, int x, bit el, bit ee, bit ew, int ec);
        tbl.push_back('{c, v, x, el, ee, ew, ec});
    endfunction

    function automatic int trailing_good();
        int t = 0;
        for (int i = m_hist.size() - 1; i > 0; i--) begin
            if (m_hist[i] == (m_hist[i-1] + 1) % MODV) t++;
            else break;
        end
        return t;
    endfunction

    task automatic model_step(bit c, bit v, int x, output bit ee, output bit ew);
        ee = 1'b0;
        ew = 1'b0;
        if (c) begin
            m_hist.delete();
            m_locked = 1'b0;
            m_errcnt = 0;
        end else if (v) begin
            if (m_hist.size() > 0) begin
                int p = m_hist[$];
                bit good = (x == (p + 1) % MODV);
                if (m_locked && !good) begin
                    ee = 1'b1;
                    if (m_errcnt < ERR_MAX) m_errcnt++;
                end
                if (m_locked && p == MODV - 1 && x == 0) ew = 1'b1;
            end
            m_hist.push_back(x);
            while (m_hist.size() > LOCK_LEN + 1) void'(m_hist.pop_front());
            m_locked = (trailing_good() >= LOCK_LEN);
        end
    endtask

    initial begin
        int  cur;
        int  g;
        bit  ee;
        bit  ew;

        reset    = 1'b1;
        clr      = 1'b0;
        valid    = 1'b0;
        count_in = '0;
        #12;
        chk_out("reset", 0, 0, 0, 0);
        reset = 1'b0;

        // Lock on 0..4, run to 10, break at 15, relock, wrap, idle gap, repeat.
        for (int x = 0; x <= 3; x++) add(0, 1, x, 0, 0, 0, 0);
        add(0, 1, 4, 1, 0, 0, 0);
        for (int x = 5; x <= 10; x++) add(0, 1, x, 1, 0, 0, 0);
        add(0, 1, 15, 0, 1, 0, 1);
        for (int x = 16; x <= 18; x++) add(0, 1, x, 0, 0, 0, 1);
        add(0, 1, 19, 1, 0, 0, 1);
        for (int x = 20; x <= 31; x++) add(0, 1, x, 1, 0, 0, 1);
        add(0, 1, 0, 1, 0, 1, 1);
        add(0, 1, 1, 1, 0, 0, 1);
        for (int k = 0; k < 5; k++) add(0, 0, 9, 1, 0, 0, 1);
        add(0, 1, 2, 1, 0, 0, 1);
        add(0, 1, 2, 0, 1, 0, 2);

        foreach (tbl[i]) begin
            step(tbl[i].c, tbl[i].v, tbl[i].x);
            chk_out($sformatf("vec%0d", i), tbl[i].el, tbl[i].ee, tbl[i].ew, tbl[i].ec);
        end

        // Saturation: 260 lock-then-break cycles.
        step(1, 0, 0);
        chk_out("sat_clr", 0, 0, 0, 0);
        cur = 0;
        step(0, 1, cur);
        for (int i = 0; i < 260; i++) begin
            for (int k = 0; k < 4; k++) begin
                cur = (cur + 1) % MODV;
                step(0, 1, cur);
            end
            if (i == 0) chk("sat_lock", int'(locked), 1);
            cur = (cur + 7) % MODV;
            step(0, 1, cur);
            if (i == 254 || i == 255 || i == 259)
                chk_out($sformatf("sat%0d", i), 0, 1, 0, (i + 1 > ERR_MAX) ? ERR_MAX : i + 1);
        end

        // clr beats valid: sample 7 must not be retained.
        step(1, 1, 7);
        chk_out("clr_valid", 0, 0, 0, 0);
        for (int x = 8; x <= 11; x++) step(0, 1, x);
        chk("clr_discard", int'(locked), 0);
        step(0, 1, 12);
        chk("clr_relock", int'(locked), 1);

        // Asynchronous reset mid-lock, with golden up-counter as source.
        g = 20;
        step(0, 1, g);
        chk_out("pre_rst_err", 0, 1, 0, 1);
        for (int k = 0; k < 4; k++) begin
            g = (g + 1) % MODV;
            step(0, 1, g);
        end
        chk_out("pre_rst_lock", 1, 0, 0, 1);
        #3;
        reset = 1'b1;
        #1;
        chk_out("async_rst", 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            g = (g + 1) % MODV;
            step(0, 1, g);
        end
        chk("rst_reacq", int'(locked), 0);
        g = (g + 1) % MODV;
        step(0, 1, g);
        chk("rst_relock", int'(locked), 1);

        // Randomized traffic against the model.
        step(1, 0, 0);
        model_step(1, 0, 0, ee, ew);
        for (int i = 0; i < 800; i++) begin
            int r = $urandom_range(0, 99);
            bit c = 1'b0;
            bit v = 1'b1;
            int x;
            int p = (m_hist.size() > 0) ? m_hist[$] : int'($urandom_range(0, MODV - 1));
            x = (p + 1) % MODV;
            if (r < 2)       c = 1'b1;
            else if (r < 14) v = 1'b0;
            else if (r < 22) x = $urandom_range(0, MODV - 1);
            else if (r < 26) x = p;
            step(c, v, x);
            model_step(c, v, x, ee, ew);
            chk_out($sformatf("rnd%0d", i), int'(m_locked), int'(ee), int'(ew), m_errcnt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
